dvp_tx_gen: RTL

- DVP transmitter: the camera-side end of the DVP link. Emits an OV5640-style RGB565 byte stream on pclk/vsync/href/data.
- Pixel source is either an upstream valid/ready stream or an internal test pattern.
- Used to drive DVP_Capture without a physical sensor, both in simulation and for on-board loopback. Sits in place of the camera pins ahead of the DDR write path.

---
 rtl/dvp_tx_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dvp_tx_gen.sv
// dvp_tx_gen: camera-side DVP transmitter producing an OV5640-style RGB565
// byte stream (pclk = clk/2, vsync, href, 8-bit data). Pixels come either from
// an upstream valid/ready stream or from an internal x/y test pattern.
`timescale 1ns/1ps
module dvp_tx_gen #(
   parameter int IMAGE_WIDTH  = 800,
   parameter int IMAGE_HEIGHT = 480,
   parameter int H_BLANK      = 160,
   parameter int VSYNC_LINES  = 4,
   parameter int V_BP_LINES   = 8,
   parameter int V_FP_LINES   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        src_sel,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
   output logic        dvp_pclk,
   output logic        dvp_vsync,
   output logic        dvp_href,
   output logic [7:0]  dvp_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        underrun,
   output logic        busy
);

   localparam int LINE_TICKS   = 2 * IMAGE_WIDTH + H_BLANK;
   localparam int ACTIVE_TICKS = 2 * IMAGE_WIDTH;
   localparam int MAX_LINES_A  = (VSYNC_LINES > V_BP_LINES) ? VSYNC_LINES : V_BP_LINES;
   localparam int MAX_LINES_B  = (IMAGE_HEIGHT > V_FP_LINES) ? IMAGE_HEIGHT : V_FP_LINES;
   localparam int MAX_LINES    = (MAX_LINES_A > MAX_LINES_B) ? MAX_LINES_A : MAX_LINES_B;
   localparam int TW           = $clog2(LINE_TICKS);
   localparam int LW           = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

   typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

   state_t        state;
   state_t        after_state;
   logic          phase;
   logic [TW-1:0] tick_cnt;
   logic [LW-1:0] line_cnt;
   logic          src_ext;
   logic [7:0]    low_byte;

   logic          tick;
   logic          in_pixels;
   logic          first_byte;
   logic          line_end;
   logic          last_line;
   logic          frame_end;
   int            state_lines;
   logic [7:0]    px8;
   logic [7:0]    py8;
   logic [7:0]    sum8;
   logic [15:0]   pattern_px;
   logic [15:0]   next_px;

   // The counters always describe the tick about to be emitted, so every
   // decode below is for the upcoming tick edge.
   assign tick       = phase && (state != IDLE);
   assign in_pixels  = (state == ACTIVE) && (tick_cnt < TW'(ACTIVE_TICKS));
   assign first_byte = in_pixels && !tick_cnt[0];
   assign line_end   = (tick_cnt == TW'(LINE_TICKS - 1));
   assign last_line  = (int'(line_cnt) == state_lines - 1);
   assign frame_end  = line_end && last_line &&
                       ((state == VFP) || ((state == ACTIVE) && (V_FP_LINES == 0)));
   assign pix_ready  = tick && first_byte && src_ext;
   assign dvp_pclk   = phase;

   // Line count of the current vertical region and the region that follows it.
   always_comb begin
      state_lines = 1;
      after_state = VSYNC;
      case (state)
         VSYNC: begin
            state_lines = VSYNC_LINES;
            after_state = (V_BP_LINES > 0) ? VBP : ACTIVE;
         end
         VBP: begin
            state_lines = V_BP_LINES;
            after_state = ACTIVE;
         end
         ACTIVE: begin
            state_lines = IMAGE_HEIGHT;
            after_state = VFP;
         end
         VFP: begin
            state_lines = V_FP_LINES;
            after_state = VSYNC;
         end
         default: begin
            state_lines = 1;
            after_state = VSYNC;
         end
      endcase
   end

   // Test pattern from the pixel index and active line, 8-bit truncated, and
   // selection of the pixel sent on the next first-byte tick.
   always_comb begin
      px8        = 8'(tick_cnt >> 1);
      py8        = 8'(line_cnt);
      sum8       = px8 + py8;
      pattern_px = {px8[7:3], py8[7:2], sum8[7:3]};
      if (src_ext) next_px = pix_valid ? pix_data : 16'h0000;
      else         next_px = pattern_px;
   end

   // Frame FSM, tick counters and registered DVP outputs; everything visible
   // on the DVP pins changes only on ticks (falling dvp_pclk).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         phase       <= 1'b0;
         tick_cnt    <= '0;
         line_cnt    <= '0;
         src_ext     <= 1'b0;
         low_byte    <= 8'h00;
         dvp_vsync   <= 1'b0;
         dvp_href    <= 1'b0;
         dvp_data    <= 8'h00;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         if (state == IDLE) begin
            phase <= 1'b0;
            if (enable) begin
               state    <= VSYNC;
               src_ext  <= src_sel;
               busy     <= 1'b1;
               tick_cnt <= '0;
               line_cnt <= '0;
            end
         end else begin
            phase <= ~phase;
            if (tick) begin
               dvp_vsync   <= (state == VSYNC);
               frame_start <= (state == VSYNC) && (line_cnt == '0) && (tick_cnt == '0);
               if (first_byte) begin
                  dvp_href <= 1'b1;
                  dvp_data <= next_px[15:8];
                  low_byte <= next_px[7:0];
                  if (src_ext && !pix_valid) underrun <= 1'b1;
               end else if (in_pixels) begin
                  dvp_href <= 1'b1;
                  dvp_data <= low_byte;
               end else begin
                  dvp_href <= 1'b0;
                  dvp_data <= 8'h00;
               end
               if (line_end) begin
                  tick_cnt <= '0;
                  if (last_line) begin
                     line_cnt <= '0;
                     if (frame_end) begin
                        frame_done <= 1'b1;
                        if (enable) begin
                           state   <= VSYNC;
                           src_ext <= src_sel;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        state <= after_state;
                     end
                  end else begin
                     line_cnt <= line_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule
